// File: rtl/dds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dds_pkg : shared constants and types for the DDS sweep sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dds_pkg;

   localparam int FW_W = 32;
   localparam int DW_W = 24;

   localparam logic [1:0] SWEEP_SINGLE = 2'd0;
   localparam logic [1:0] SWEEP_SAW    = 2'd1;
   localparam logic [1:0] SWEEP_TRI    = 2'd2;
   localparam logic [1:0] SWEEP_RSVD   = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sweep_next_freq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sweep_next_freq : next sweep frequency with carry/borrow clamping    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sweep_next_freq #(
   parameter int FW_W = 32
) (
   input  logic [FW_W-1:0] cur,
   input  logic [FW_W-1:0] lo,
   input  logic [FW_W-1:0] hi,
   input  logic [FW_W-1:0] step,
   input  logic [1:0]      mode,
   input  logic            down,
   output logic [FW_W-1:0] nxt,
   output logic            nxt_down,
   output logic            leg_end
);
   import dds_pkg::*;

   logic [FW_W:0]   up_sum;
   logic [FW_W:0]   dn_diff;
   logic [FW_W-1:0] up_val;
   logic [FW_W-1:0] dn_val;
   logic            at_top;
   logic            at_bot;

   // The extra top bit catches wrap-around so an overflowing step still clamps.
   assign up_sum  = {1'b0, cur} + {1'b0, step};
   assign dn_diff = {1'b0, cur} - {1'b0, step};
   assign up_val  = (up_sum[FW_W] || (up_sum[FW_W-1:0] >= hi)) ? hi : up_sum[FW_W-1:0];
   assign dn_val  = (dn_diff[FW_W] || (dn_diff[FW_W-1:0] <= lo)) ? lo : dn_diff[FW_W-1:0];

   assign at_top  = !down && (cur == hi);
   assign at_bot  = down && (cur == lo);
   assign leg_end = at_top;

   always_comb begin
      nxt      = up_val;
      nxt_down = down;
      if (at_top) begin
         case (mode)
            SWEEP_SAW: nxt = lo;
            SWEEP_TRI: begin
               nxt      = dn_val;
               nxt_down = 1'b1;
            end
            default:   nxt = cur;
         endcase
      end else if (at_bot) begin
         nxt      = up_val;
         nxt_down = 1'b0;
      end else if (down) begin
         nxt = dn_val;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dds_sweep_ctrl : linear frequency-sweep sequencer feeding a DDS core |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dds_sweep_ctrl #(
   parameter int FW_W = dds_pkg::FW_W,
   parameter int DW_W = dds_pkg::DW_W
) (
   input  logic            clk_dds,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [FW_W-1:0] f_start,
   input  logic [FW_W-1:0] f_stop,
   input  logic [FW_W-1:0] f_step,
   input  logic [DW_W-1:0] dwell,
   input  logic [1:0]      sweep_mode,
   input  logic [11:0]     p_word_in,
   input  logic [1:0]      wave_type_in,
   output logic [FW_W-1:0] f_word,
   output logic [11:0]     p_word,
   output logic [1:0]      wave_type,
   output logic            dds_en,
   output logic            set_flag,
   output logic            busy,
   output logic            done,
   output logic            cfg_err
);
   import dds_pkg::*;

   localparam logic [DW_W-1:0] DW_ONE = {{(DW_W-1){1'b0}}, 1'b1};

   state_t          state, next_state;
   logic [FW_W-1:0] sh_start, sh_stop, sh_step;
   logic [DW_W-1:0] sh_dwell;
   logic [1:0]      sh_mode;
   logic [DW_W-1:0] dwell_cnt;
   logic            down;

   logic [FW_W-1:0] nxt_start, nxt_stop, nxt_step, nxt_f;
   logic [DW_W-1:0] nxt_dwell, nxt_cnt;
   logic [1:0]      nxt_mode, nxt_wt;
   logic [11:0]     nxt_pw;
   logic            nxt_down, nxt_en, nxt_sf, nxt_busy, nxt_done, nxt_err;

   logic [FW_W-1:0] step_f;
   logic            step_down;
   logic            leg_end;
   logic            cfg_ok;

   sweep_next_freq #(.FW_W(FW_W)) u_next (
      .cur      (f_word),
      .lo       (sh_start),
      .hi       (sh_stop),
      .step     (sh_step),
      .mode     (sh_mode),
      .down     (down),
      .nxt      (step_f),
      .nxt_down (step_down),
      .leg_end  (leg_end)
   );

   assign cfg_ok = (f_step != '0) && (f_stop > f_start) && (dwell != '0) &&
                   (sweep_mode != SWEEP_RSVD);

   always_ff @(posedge clk_dds) begin
      if (rst) begin
         state     <= ST_IDLE;
         sh_start  <= '0;
         sh_stop   <= '0;
         sh_step   <= '0;
         sh_dwell  <= '0;
         sh_mode   <= '0;
         dwell_cnt <= '0;
         down      <= 1'b0;
         f_word    <= '0;
         p_word    <= '0;
         wave_type <= '0;
         dds_en    <= 1'b0;
         set_flag  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state     <= next_state;
         sh_start  <= nxt_start;
         sh_stop   <= nxt_stop;
         sh_step   <= nxt_step;
         sh_dwell  <= nxt_dwell;
         sh_mode   <= nxt_mode;
         dwell_cnt <= nxt_cnt;
         down      <= nxt_down;
         f_word    <= nxt_f;
         p_word    <= nxt_pw;
         wave_type <= nxt_wt;
         dds_en    <= nxt_en;
         set_flag  <= nxt_sf;
         busy      <= nxt_busy;
         done      <= nxt_done;
         cfg_err   <= nxt_err;
      end
   end

   always_comb begin
      next_state = state;
      nxt_start  = sh_start;
      nxt_stop   = sh_stop;
      nxt_step   = sh_step;
      nxt_dwell  = sh_dwell;
      nxt_mode   = sh_mode;
      nxt_cnt    = dwell_cnt;
      nxt_down   = down;
      nxt_f      = f_word;
      nxt_pw     = p_word;
      nxt_wt     = wave_type;
      nxt_en     = dds_en;
      nxt_sf     = 1'b0;
      nxt_busy   = busy;
      nxt_done   = 1'b0;
      nxt_err    = 1'b0;

      case (state)
         ST_IDLE: begin
            nxt_en   = 1'b0;
            nxt_busy = 1'b0;
            if (start && !abort) begin
               if (cfg_ok) begin
                  next_state = ST_RUN;
                  nxt_start  = f_start;
                  nxt_stop   = f_stop;
                  nxt_step   = f_step;
                  nxt_dwell  = dwell;
                  nxt_mode   = sweep_mode;
                  nxt_cnt    = dwell - DW_ONE;
                  nxt_down   = 1'b0;
                  nxt_f      = f_start;
                  nxt_pw     = p_word_in;
                  nxt_wt     = wave_type_in;
                  nxt_en     = 1'b1;
                  nxt_sf     = 1'b1;
                  nxt_busy   = 1'b1;
               end else begin
                  nxt_err = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               next_state = ST_IDLE;
               nxt_en     = 1'b0;
               nxt_busy   = 1'b0;
            end else if (dwell_cnt == '0) begin
               nxt_cnt = sh_dwell - DW_ONE;
               // A single sweep ends after the f_stop dwell; f_word keeps f_stop.
               if (leg_end && (sh_mode == SWEEP_SINGLE)) begin
                  next_state = ST_IDLE;
                  nxt_en     = 1'b0;
                  nxt_busy   = 1'b0;
                  nxt_done   = 1'b1;
               end else begin
                  nxt_f    = step_f;
                  nxt_down = step_down;
               end
            end else begin
               nxt_cnt = dwell_cnt - DW_ONE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dds_sweep_ctrl : scoreboard bench for the DDS sweep sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dds_sweep_ctrl;

   logic        clk_dds = 1'b0;
   logic        rst, start, abort;
   logic [31:0] f_start, f_stop, f_step;
   logic [23:0] dwell;
   logic [1:0]  sweep_mode, wave_type_in;
   logic [11:0] p_word_in;
   logic [31:0] f_word;
   logic [11:0] p_word;
   logic [1:0]  wave_type;
   logic        dds_en, set_flag, busy, done, cfg_err;

   always #5 clk_dds = ~clk_dds;

   dds_sweep_ctrl dut (
      .clk_dds      (clk_dds),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .f_start      (f_start),
      .f_stop       (f_stop),
      .f_step       (f_step),
      .dwell        (dwell),
      .sweep_mode   (sweep_mode),
      .p_word_in    (p_word_in),
      .wave_type_in (wave_type_in),
      .f_word       (f_word),
      .p_word       (p_word),
      .wave_type    (wave_type),
      .dds_en       (dds_en),
      .set_flag     (set_flag),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err)
   );

   typedef struct {
      logic [31:0] fw;
      logic [11:0] pw;
      logic [1:0]  wt;
      logic        en, sf, bsy, dn, err;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] last_fw  = '0;
   logic [11:0] cur_pw   = '0;
   logic [1:0]  cur_wt   = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   task automatic push_exp(input logic [31:0] fw, input logic en, input logic sf,
                           input logic bsy, input logic dn, input logic err);
      exp_t e;
      e.fw = fw; e.pw = cur_pw; e.wt = cur_wt;
      e.en = en; e.sf = sf; e.bsy = bsy; e.dn = dn; e.err = err;
      exp_q.push_back(e);
      last_fw = fw;
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) push_exp(last_fw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reference sequence: every value held dwell cycles, clamped at the bounds.
   task automatic push_sweep(input logic [31:0] lo, input logic [31:0] hi,
                             input logic [31:0] stp, input int dw, input int mode,
                             input int ncyc);
      logic [32:0] v;
      logic        dir_dn;
      int          k;
      v = {1'b0, lo}; dir_dn = 1'b0; k = 0;
      while (k < ncyc) begin
         for (int d = 0; d < dw && k < ncyc; d++) begin
            push_exp(v[31:0], 1'b1, (k == 0), 1'b1, 1'b0, 1'b0);
            k++;
         end
         if (k >= ncyc) break;
         if (!dir_dn && v[31:0] == hi) begin
            if (mode == 0) begin
               push_exp(hi, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
               break;
            end else if (mode == 1) begin
               v = {1'b0, lo};
            end else begin
               dir_dn = 1'b1;
               v = (v < {1'b0, stp} || v - {1'b0, stp} <= {1'b0, lo}) ? {1'b0, lo} : v - {1'b0, stp};
            end
         end else if (dir_dn && v[31:0] == lo) begin
            dir_dn = 1'b0;
            v = (v + {1'b0, stp} >= {1'b0, hi}) ? {1'b0, hi} : v + {1'b0, stp};
         end else if (dir_dn) begin
            v = (v < {1'b0, stp} || v - {1'b0, stp} <= {1'b0, lo}) ? {1'b0, lo} : v - {1'b0, stp};
         end else begin
            v = (v + {1'b0, stp} >= {1'b0, hi}) ? {1'b0, hi} : v + {1'b0, stp};
         end
      end
   endtask

   task automatic run_cycle();
      exp_t e;
      @(posedge clk_dds);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("f_word",    f_word,           e.fw);
         check("p_word",    32'(p_word),      32'(e.pw));
         check("wave_type", 32'(wave_type),   32'(e.wt));
         check("dds_en",    32'(dds_en),      32'(e.en));
         check("set_flag",  32'(set_flag),    32'(e.sf));
         check("busy",      32'(busy),        32'(e.bsy));
         check("done",      32'(done),        32'(e.dn));
         check("cfg_err",   32'(cfg_err),     32'(e.err));
      end
   endtask

   task automatic drain();
      while (exp_q.size() > 0) run_cycle();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      run_cycle();
      start = 1'b0;
   endtask

   task automatic set_cfg(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] stp,
                          input logic [23:0] dw, input logic [1:0] md,
                          input logic [11:0] pw, input logic [1:0] wt);
      f_start = lo; f_stop = hi; f_step = stp; dwell = dw; sweep_mode = md;
      p_word_in = pw; wave_type_in = wt;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      set_cfg(32'd0, 32'd0, 32'd0, 24'd0, 2'd0, 12'd0, 2'd0);
      run_cycle();
      push_idle(2);
      drain();
      rst = 1'b0;
      push_idle(1);
      drain();

      // single sweep 100..130 step 10, dwell 4
      set_cfg(32'd100, 32'd130, 32'd10, 24'd4, 2'd0, 12'h123, 2'd2);
      cur_pw = 12'h123; cur_wt = 2'd2;
      push_sweep(32'd100, 32'd130, 32'd10, 4, 0, 1000);
      pulse_start();
      drain();
      push_idle(2);
      drain();

      // clamp below f_stop
      set_cfg(32'd100, 32'd125, 32'd10, 24'd2, 2'd0, 12'h456, 2'd1);
      cur_pw = 12'h456; cur_wt = 2'd1;
      push_sweep(32'd100, 32'd125, 32'd10, 2, 0, 1000);
      pulse_start();
      drain();

      // carry out of the top bit
      set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd1, 2'd0, 12'h001, 2'd3);
      cur_pw = 12'h001; cur_wt = 2'd3;
      push_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 1, 0, 1000);
      pulse_start();
      drain();

      // triangle, config inputs disturbed mid-sweep, then abort mid-dwell
      set_cfg(32'd100, 32'd120, 32'd10, 24'd2, 2'd2, 12'hABC, 2'd0);
      cur_pw = 12'hABC; cur_wt = 2'd0;
      push_sweep(32'd100, 32'd120, 32'd10, 2, 2, 25);
      pulse_start();
      set_cfg(32'd7, 32'd999, 32'd3, 24'd9, 2'd1, 12'h777, 2'd3);
      drain();
      abort = 1'b1;
      push_idle(1);
      run_cycle();
      abort = 1'b0;
      push_idle(2);
      drain();

      // sawtooth, dwell 1, with a start during RUN
      set_cfg(32'd100, 32'd120, 32'd10, 24'd1, 2'd1, 12'h321, 2'd1);
      cur_pw = 12'h321; cur_wt = 2'd1;
      push_sweep(32'd100, 32'd120, 32'd10, 1, 1, 10);
      pulse_start();
      run_cycle(); run_cycle(); run_cycle();
      f_start = 32'd5;
      pulse_start();
      drain();
      abort = 1'b1;
      push_idle(1);
      run_cycle();
      abort = 1'b0;

      // start and abort together
      set_cfg(32'd10, 32'd50, 32'd5, 24'd1, 2'd0, 12'hFFF, 2'd2);
      push_idle(1);
      start = 1'b1; abort = 1'b1;
      run_cycle();
      start = 1'b0; abort = 1'b0;
      push_idle(2);
      drain();

      // rejected starts: zero step, equal bounds, reserved mode
      set_cfg(32'd10, 32'd50, 32'd0, 24'd1, 2'd0, 12'h0F0, 2'd1);
      push_exp(last_fw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse_start();
      push_idle(1);
      drain();
      set_cfg(32'd50, 32'd50, 32'd5, 24'd1, 2'd0, 12'h0F0, 2'd1);
      push_exp(last_fw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse_start();
      push_idle(1);
      drain();
      set_cfg(32'd10, 32'd50, 32'd5, 24'd1, 2'd3, 12'h0F0, 2'd1);
      push_exp(last_fw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse_start();
      push_idle(1);
      drain();

      // reset while set_flag is high
      set_cfg(32'd200, 32'd900, 32'd1, 24'd3, 2'd1, 12'h5A5, 2'd3);
      cur_pw = 12'h5A5; cur_wt = 2'd3;
      push_sweep(32'd200, 32'd900, 32'd1, 3, 1, 1);
      pulse_start();
      rst = 1'b1;
      cur_pw = '0; cur_wt = '0;
      push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cycle();
      rst = 1'b0;
      push_idle(2);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
